// File: rtl/fir_mac_sequencer_if.sv
// Sample-in / result-out stream bundle for the FIR MAC sequencer.
// The slave modport is the sequencer's view; the master modport is the view of
// the sample source and the downstream consumer.
interface fir_mac_sequencer_if #(
  parameter int unsigned L     = 10,
  parameter int unsigned ACC_W = 25
);
  logic             in_valid;
  logic             in_ready;
  logic [L-1:0]     in_sample;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;

  modport master (
    output in_valid,
    output in_sample,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data
  );
endinterface

// File: rtl/fir_mac_sequencer.sv
// Time-multiplexed FIR controller: accepts a sample, strobes it into the
// external delay line, walks all taps through one signed MAC against the
// coefficient ROM, then offers the sum on a valid/ready output.
module fir_mac_sequencer #(
  parameter int unsigned N     = 20,
  parameter int unsigned L     = 10,
  parameter int unsigned C     = 10,
  parameter int unsigned AW    = 5,
  parameter int unsigned ACC_W = L + C + AW
) (
  input  logic                  clk_clk,
  input  logic                  reset_n,
  fir_mac_sequencer_if.slave    stream,
  output logic                  shift_en,
  output logic [L-1:0]          shift_data,
  output logic [AW-1:0]         tap_sel,
  input  logic [L-1:0]          tap_data,
  output logic [AW-1:0]         coef_addr,
  input  logic [C-1:0]          coef_data,
  output logic                  busy
);

  localparam int unsigned PW = L + C;
  localparam logic [AW-1:0] LastTap = AW'(N - 1);

  typedef enum logic [1:0] {StIdle, StShift, StMac, StOut} state_e;

  state_e           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             shift_en_q, shift_en_d;
  logic [L-1:0]     shift_data_q, shift_data_d;
  logic [AW-1:0]    tap_sel_q, tap_sel_d;
  logic             out_valid_q, out_valid_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             busy_q, busy_d;

  logic signed [PW-1:0] tap_ext;
  logic signed [PW-1:0] coef_ext;
  logic signed [PW-1:0] prod;
  logic [ACC_W-1:0]     prod_ext;
  logic [ACC_W-1:0]     acc_sum;

  // Signed L x C product kept at full L+C precision, then sign-extended into the accumulator.
  always_comb begin
    tap_ext  = {{C{tap_data[L-1]}}, tap_data};
    coef_ext = {{L{coef_data[C-1]}}, coef_data};
    prod     = tap_ext * coef_ext;
    prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};
    acc_sum  = acc_q + prod_ext;
  end

  // Next-state and registered-output decode for the sequencer FSM.
  always_comb begin
    state_d      = state_q;
    in_ready_d   = in_ready_q;
    shift_en_d   = shift_en_q;
    shift_data_d = shift_data_q;
    tap_sel_d    = tap_sel_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    acc_d        = acc_q;
    busy_d       = busy_q;
    unique case (state_q)
      StIdle: begin
        if (stream.in_valid) begin
          state_d      = StShift;
          shift_data_d = stream.in_sample;
          shift_en_d   = 1'b1;
          in_ready_d   = 1'b0;
          busy_d       = 1'b1;
        end
      end
      StShift: begin
        // tap_sel keeps its old value this cycle; k=0 takes effect in the first MAC cycle.
        state_d    = StMac;
        shift_en_d = 1'b0;
        acc_d      = '0;
        tap_sel_d  = '0;
      end
      StMac: begin
        acc_d = acc_sum;
        if (tap_sel_q == LastTap) begin
          state_d     = StOut;
          out_valid_d = 1'b1;
          out_data_d  = acc_sum;
        end else begin
          tap_sel_d = tap_sel_q + 1'b1;
        end
      end
      StOut: begin
        if (stream.out_ready) begin
          state_d     = StIdle;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk_clk) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      in_ready_q   <= 1'b1;
      shift_en_q   <= 1'b0;
      shift_data_q <= '0;
      tap_sel_q    <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      acc_q        <= '0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      in_ready_q   <= in_ready_d;
      shift_en_q   <= shift_en_d;
      shift_data_q <= shift_data_d;
      tap_sel_q    <= tap_sel_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      acc_q        <= acc_d;
      busy_q       <= busy_d;
    end
  end

  assign stream.in_ready  = in_ready_q;
  assign stream.out_valid = out_valid_q;
  assign stream.out_data  = out_data_q;
  assign shift_en         = shift_en_q;
  assign shift_data       = shift_data_q;
  assign tap_sel          = tap_sel_q;
  assign coef_addr        = tap_sel_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed + randomized bench for fir_mac_sequencer with an external delay line,
// a coefficient ROM and a sum-of-products reference model.
module tb_fir_mac_sequencer;

  localparam int unsigned N     = 20;
  localparam int unsigned L     = 10;
  localparam int unsigned C     = 10;
  localparam int unsigned AW    = 5;
  localparam int unsigned ACC_W = L + C + AW;

  logic clk;
  logic reset_n;
  logic dl_clr;

  logic          shift_en;
  logic [L-1:0]  shift_data;
  logic [AW-1:0] tap_sel;
  logic [L-1:0]  tap_data;
  logic [AW-1:0] coef_addr;
  logic [C-1:0]  coef_data;
  logic          busy;

  fir_mac_sequencer_if #(.L(L), .ACC_W(ACC_W)) bus ();

  fir_mac_sequencer #(.N(N), .L(L), .C(C), .AW(AW), .ACC_W(ACC_W)) dut (
    .clk_clk    (clk),
    .reset_n    (reset_n),
    .stream     (bus),
    .shift_en   (shift_en),
    .shift_data (shift_data),
    .tap_sel    (tap_sel),
    .tap_data   (tap_data),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External delay line and coefficient ROM.
  logic [L-1:0]        dl   [N];
  logic signed [C-1:0] coef [N];

  always @(posedge clk) begin
    if (dl_clr) begin
      for (int i = 0; i < N; i++) dl[i] <= '0;
    end else if (shift_en) begin
      for (int i = N - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= shift_data;
    end
  end

  assign tap_data  = dl[tap_sel];
  assign coef_data = coef[coef_addr];

  // Reference model: history of accepted samples, newest first.
  longint           hist [N];
  logic [ACC_W-1:0] exp_q [$];
  logic [ACC_W-1:0] last_out;
  int               checks;
  int               errors;
  int               cycle;
  int               accepts;
  int               shift_cnt;

  function automatic longint model_out();
    longint s = 0;
    for (int k = 0; k < N; k++) s += hist[k] * longint'(coef[k]);
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: samples handshakes before the edge, updates model/scoreboard after it.
  task automatic tick();
    logic             acc_hs;
    logic             out_hs;
    logic             rst_ok;
    logic [L-1:0]     smp;
    logic [ACC_W-1:0] od;
    rst_ok = reset_n;
    acc_hs = bus.in_valid && bus.in_ready;
    out_hs = bus.out_valid && bus.out_ready;
    smp    = bus.in_sample;
    od     = bus.out_data;
    @(posedge clk);
    #1;
    cycle++;
    if (!rst_ok) begin
      exp_q.delete();
    end else begin
      if (acc_hs) begin
        for (int k = N - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(smp));
        exp_q.push_back(ACC_W'(model_out()));
        accepts++;
      end
      if (out_hs) begin
        check("out_expected_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) check("out_data", 64'(od), 64'(exp_q.pop_front()));
        last_out = od;
      end
    end
    if (shift_en) shift_cnt++;
  endtask

  // Full transaction: accept, latency, optional backpressure for 'hold' cycles, handshake.
  task automatic send(input logic [L-1:0] s, input int hold);
    int n;
    int acc_c;
    int snap;
    logic [ACC_W-1:0] od0;
    bus.in_valid  = 1'b1;
    bus.in_sample = s;
    bus.out_ready = (hold == 0);
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick();
      n++;
    end
    check("accept_wait", 64'(bus.in_ready), 64'(1));
    acc_c = cycle;
    snap  = shift_cnt;
    tick();
    bus.in_valid = 1'b0;
    check("shift_strobe", 64'(shift_en), 64'(1));
    check("shift_data", 64'(shift_data), 64'(s));
    check("busy_shift", 64'(busy), 64'(1));
    tick();
    check("shift_one_cycle", 64'(shift_en), 64'(0));
    n = 0;
    while (!bus.out_valid && n < N + 10) begin
      tick();
      n++;
    end
    check("out_valid_wait", 64'(bus.out_valid), 64'(1));
    check("latency", 64'(cycle - acc_c), 64'(N + 2));
    check("shift_count", 64'(shift_cnt - snap), 64'(1));
    for (int i = 0; i < hold; i++) begin
      od0 = bus.out_data;
      bus.in_valid  = 1'b1;
      bus.in_sample = L'($urandom);
      tick();
      check("bp_valid", 64'(bus.out_valid), 64'(1));
      check("bp_data", 64'(bus.out_data), 64'(od0));
      check("bp_in_ready", 64'(bus.in_ready), 64'(0));
      check("bp_no_shift", 64'(shift_en), 64'(0));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    check("out_drop", 64'(bus.out_valid), 64'(0));
    check("idle_ready", 64'(bus.in_ready), 64'(1));
    check("idle_busy", 64'(busy), 64'(0));
  endtask

  initial begin
    int prev;
    int a0;
    int s0;
    int n;
    checks = 0; errors = 0; cycle = 0; accepts = 0; shift_cnt = 0;
    last_out = '0;
    for (int k = 0; k < N; k++) begin
      hist[k] = 0;
      coef[k] = C'(k + 1);
    end
    bus.in_valid = 1'b0; bus.in_sample = '0; bus.out_ready = 1'b1;
    reset_n = 1'b0; dl_clr = 1'b1;
    repeat (3) tick();
    reset_n = 1'b1; dl_clr = 1'b0;
    tick();

    // Reset state.
    check("rst_in_ready", 64'(bus.in_ready), 64'(1));
    check("rst_shift_en", 64'(shift_en), 64'(0));
    check("rst_shift_data", 64'(shift_data), 64'(0));
    check("rst_tap_sel", 64'(tap_sel), 64'(0));
    check("rst_coef_addr", 64'(coef_addr), 64'(0));
    check("rst_out_valid", 64'(bus.out_valid), 64'(0));
    check("rst_out_data", 64'(bus.out_data), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    // Impulse response with coef[k]=k+1.
    send(L'(1), 0);
    check("impulse_0", 64'(last_out), 64'(1));
    for (int k = 1; k <= N; k++) begin
      send('0, 0);
      check($sformatf("impulse_%0d", k), 64'(last_out), 64'((k < N) ? k + 1 : 0));
    end

    // Full-scale negative: 20 * (-512 * -512).
    for (int k = 0; k < N; k++) coef[k] = -C'(512);
    for (int k = 0; k < N; k++) send(L'(-512), 0);
    check("full_scale", 64'(last_out), 64'(ACC_W'(5242880)));

    // Backpressure for 7 cycles.
    for (int k = 0; k < N; k++) coef[k] = C'($urandom);
    send(L'($urandom), 7);

    // in_valid held high: one accept per N+3 cycles.
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    a0 = accepts; s0 = shift_cnt; prev = -1;
    for (int i = 0; i < 100; i++) begin
      bus.in_sample = L'($urandom);
      if (bus.in_ready) begin
        if (prev >= 0) check("accept_spacing", 64'(cycle - prev), 64'(N + 3));
        prev = cycle;
      end
      tick();
    end
    bus.in_valid = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check("drain_idle", 64'(busy), 64'(0));
    check("busy_accepts", 64'(accepts - a0), 64'(5));
    check("busy_shift_eq_accept", 64'(shift_cnt - s0), 64'(accepts - a0));

    // Reset in MAC at k=8.
    bus.in_valid  = 1'b1;
    bus.in_sample = L'($urandom);
    tick();
    bus.in_valid = 1'b0;
    repeat (9) tick();
    check("mac_k8", 64'(tap_sel), 64'(8));
    reset_n = 1'b0;
    s0 = shift_cnt;
    tick();
    reset_n = 1'b1;
    check("mrst_in_ready", 64'(bus.in_ready), 64'(1));
    check("mrst_out_valid", 64'(bus.out_valid), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_tap_sel", 64'(tap_sel), 64'(0));
    check("mrst_out_data", 64'(bus.out_data), 64'(0));
    repeat (N + 5) tick();
    check("mrst_no_result", 64'(bus.out_valid), 64'(0));
    check("mrst_no_shift", 64'(shift_cnt - s0), 64'(0));
    send(L'($urandom), 0);

    // Randomized coefficients, samples and backpressure.
    for (int k = 0; k < N; k++) coef[k] = C'($urandom);
    for (int t = 0; t < 10; t++) send(L'($urandom), int'($urandom_range(0, 4)));

    check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
